// File: rtl/conv_1x1_channel_acc.sv
// 1x1 convolution channel accumulator: sums fp_mul products over input channels per pixel.
// Optional fused output ReLU: define CONV_1X1_CHANNEL_ACC_RELU_EN.

module conv_1x1_channel_acc_fp_add #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] sum
);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [27:0] mx, my, my_sh, s, lost_mask;
    logic [9:0]  e, exp_enc;
    logic [24:0] rnd;
    logic        a_nan, b_nan, a_inf, b_inf;

    // NOTE: blocking assignments are correct here; these are combinational scratch values.
    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        d  = ex - ey;
        mx = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b000};
        lost_mask = '0;
        if (d >= 8'd27) begin
            my_sh = {27'd0, |my};
        end else begin
            lost_mask = (28'd1 << d) - 28'd1;
            my_sh = (my >> d) | {27'd0, |(my & lost_mask)};
        end
        s = (x[31] == y[31]) ? mx + my_sh : mx - my_sh;
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 10'd1) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end
        // Round to nearest even on guard/round/sticky; a denormal carrying into bit 23 becomes normal.
        rnd = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
        if (rnd[24])      exp_enc = e + 10'd1;
        else if (rnd[23]) exp_enc = e;
        else              exp_enc = 10'd0;
        res = {x[31], exp_enc[7:0], rnd[24] ? 23'd0 : rnd[22:0]};
        if (exp_enc >= 10'd255) res = {x[31], 8'hFF, 23'd0};
        if (s == 28'd0)         res = {x[31] & y[31], 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) res = 32'h7FC00000;
        else if (a_inf)                                               res = a;
        else if (b_inf)                                               res = b;
    end

    logic [31:0]        sum_pipe   [LATENCY];
    logic [LATENCY-1:0] valid_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= valid_in;
            for (int i = 1; i < LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits must be cleared.
    always_ff @(posedge clk) begin
        sum_pipe[0] <= res;
        for (int i = 1; i < LATENCY; i++) sum_pipe[i] <= sum_pipe[i-1];
    end

    assign valid_out = valid_pipe[LATENCY-1];
    assign sum       = sum_pipe[LATENCY-1];
endmodule

module conv_1x1_channel_acc #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int ADD_LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  done
);
    localparam int PXL_W = $clog2(IMAGE_SIZE > 1 ? IMAGE_SIZE : 2);
    localparam int CH_W  = $clog2(CHANNEL_NUM_IN > 1 ? CHANNEL_NUM_IN : 2);
    localparam int OCH_W = $clog2(CHANNEL_NUM_OUT > 1 ? CHANNEL_NUM_OUT : 2);

    typedef struct packed {
        logic [PXL_W-1:0] addr;
        logic             last;
        logic             frame_end;
    } tag_t;

    logic [PXL_W-1:0]      pxl_cnt;
    logic [CH_W-1:0]       ch_cnt;
    logic [OCH_W-1:0]      och_cnt;
    logic                  pxl_last, ch_first, ch_last, och_last;

    logic [DATA_WIDTH-1:0] mem [IMAGE_SIZE];
    logic [DATA_WIDTH-1:0] s1_data, s1_rd, op_b;
    logic [PXL_W-1:0]      s1_addr;
    logic                  s1_valid, s1_first, s1_last, s1_frame_end;

    tag_t                  tag_pipe [ADD_LATENCY];
    tag_t                  add_tag;
    logic                  add_valid;
    logic [DATA_WIDTH-1:0] add_sum, out_sum;

    assign pxl_last = pxl_cnt == PXL_W'(IMAGE_SIZE - 1);
    assign ch_first = ch_cnt == '0;
    assign ch_last  = ch_cnt == CH_W'(CHANNEL_NUM_IN - 1);
    assign och_last = och_cnt == OCH_W'(CHANNEL_NUM_OUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_cnt  <= '0;
            ch_cnt   <= '0;
            och_cnt  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                if (pxl_last) begin
                    pxl_cnt <= '0;
                    if (ch_last) begin
                        ch_cnt  <= '0;
                        och_cnt <= och_last ? '0 : och_cnt + OCH_W'(1);
                    end else begin
                        ch_cnt <= ch_cnt + CH_W'(1);
                    end
                end else begin
                    pxl_cnt <= pxl_cnt + PXL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            s1_data      <= pxl_in;
            s1_addr      <= pxl_cnt;
            s1_first     <= ch_first;
            s1_last      <= ch_last;
            s1_frame_end <= pxl_last && ch_last && och_last;
        end
    end

    // NOTE: the partial-sum memory is never reset; channel 0 ignores its contents.
    // Write and read addresses never collide while IMAGE_SIZE >= ADD_LATENCY+3.
    always_ff @(posedge clk) begin
        if (add_valid && !add_tag.last) mem[add_tag.addr] <= add_sum;
        if (valid_in) s1_rd <= mem[pxl_cnt];
    end

    assign op_b = s1_first ? '0 : s1_rd;

    conv_1x1_channel_acc_fp_add #(
        .LATENCY(ADD_LATENCY)
    ) u_fp_add (
        .clk      (clk),
        .reset    (reset),
        .valid_in (s1_valid),
        .a        (s1_data),
        .b        (op_b),
        .valid_out(add_valid),
        .sum      (add_sum)
    );

    always_ff @(posedge clk) begin
        tag_pipe[0] <= '{addr: s1_addr, last: s1_last, frame_end: s1_frame_end};
        for (int i = 1; i < ADD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    assign add_tag = tag_pipe[ADD_LATENCY-1];

`ifdef CONV_1X1_CHANNEL_ACC_RELU_EN
    assign out_sum = add_sum[DATA_WIDTH-1] ? '0 : add_sum;
`else
    assign out_sum = add_sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out   <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= add_valid && add_tag.last;
            done      <= add_valid && add_tag.last && add_tag.frame_end;
            if (add_valid && add_tag.last) pxl_out <= out_sum;
        end
    end
endmodule
